// File: rtl/disk_track_sync_pkg.sv
// Shared types and constants for the Disk II track sequencer.
// The optional write-back path is controlled by the macro DISK_WRITEBACK_EN.
package apple2_disk_pkg;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_WB   = 2'd1,
        DS_RD   = 2'd2
    } disk_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int DEF_SECTORS  = 13;
    localparam int DEF_TRACK_W  = 6;

    // First SD sector of a track; a constant multiply, wide enough for 6-bit tracks.
    function automatic logic [31:0] track_lba(input logic [31:0] trk, input int sectors);
        return trk * 32'(sectors);
    endfunction

endpackage

// File: rtl/disk_track_sync_if.sv
// SD block request bus: the sequencer is master (lba/rd/wr), the SD host is slave (ack).
// Handshake: rd/wr is a level held until the last sector's ack rise; each ack pulse moves one sector.
interface disk_track_sync_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/disk_track_sync_sd_burst_seq.sv
// One whole-track SD burst: ack edge detect, lba stepping, sector slot count, request drop and done pulses.
// Shared by write-back and read; the caller decides which request line the req level drives.
module sd_burst_seq
    import apple2_disk_pkg::*;
#(
    parameter int SECTORS = DEF_SECTORS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] base_lba_i,
    input  logic        abort_i,
    input  logic        sd_ack_i,
    output logic [31:0] lba_o,
    output logic        req_o,
    output logic [3:0]  sec_o,
    output logic        first_done_o,
    output logic        done_o
);

    localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

    logic        ack_q;
    logic [31:0] lba_q;
    logic        req_q;
    logic [3:0]  sec_q;
    logic        rise;
    logic        fall;

    assign rise = ~ack_q & sd_ack_i;
    assign fall = ack_q & ~sd_ack_i;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack_q <= 1'b0;
            lba_q <= '0;
            req_q <= 1'b0;
            sec_q <= '0;
        end else begin
            ack_q <= sd_ack_i;
            if (start_i) begin
                lba_q <= base_lba_i;
                sec_q <= '0;
                req_q <= 1'b1;
            end else begin
                // Dropping at the rise lets the host finish the sector in flight and then stop.
                if (rise) begin
                    lba_q <= lba_q + 32'd1;
                    if (sec_q == LAST_SEC || abort_i) begin
                        req_q <= 1'b0;
                    end
                end
                if (fall) begin
                    sec_q <= sec_q + 4'd1;
                end
            end
        end
    end

    assign lba_o        = lba_q;
    assign req_o        = req_q;
    assign sec_o        = sec_q;
    assign first_done_o = fall & (sec_q == 4'd0);
    assign done_o       = fall & ~req_q;

endmodule

// File: rtl/disk_track_sync.sv
// Disk II track cache policy: loads the track under the head, writes back dirty tracks, stalls the CPU.
// Write-back (track_dirty/flush/sd_wr) exists only when DISK_WRITEBACK_EN is defined; otherwise read-only.
module disk_track_sync
    import apple2_disk_pkg::*;
#(
    parameter int SECTORS = DEF_SECTORS,
    parameter int TRACK_W = DEF_TRACK_W
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [TRACK_W-1:0]  track,
    input  logic                track_dirty,
    input  logic                flush,
    input  logic                img_mounted,
    input  logic [63:0]         img_size,
    disk_track_sync_if.master   sd,
    output logic [3:0]          track_sec,
    output logic                cpu_wait,
    output logic                busy,
    output logic                dirty,
    output disk_state_t         state_dbg
);

    disk_state_t        state_q;
    logic [TRACK_W-1:0] cur_track_q;
    logic               cpu_wait_q;
    logic               mount_pend_q;
    logic               abort_pend_q;
    logic               start_q;
    logic [31:0]        base_q;

    logic        has_img;
    logic        trk_change;
    logic        rd_go;
    logic [31:0] seq_lba;
    logic        seq_req;
    logic [3:0]  seq_sec;
    logic        seq_first;
    logic        seq_done;

`ifdef DISK_WRITEBACK_EN
    logic dirty_q;
    logic flush_pend_q;
    logic wb_go;
    assign wb_go = ~mount_pend_q & dirty_q & has_img & (trk_change | flush_pend_q);
`else
    logic unused_wb_inputs;
    assign unused_wb_inputs = track_dirty ^ flush;
`endif

    assign has_img    = |img_size;
    assign trk_change = (track != cur_track_q);
    assign rd_go      = has_img & (mount_pend_q | trk_change);

    sd_burst_seq #(.SECTORS(SECTORS)) u_seq (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .start_i      (start_q),
        .base_lba_i   (base_q),
        .abort_i      (abort_pend_q),
        .sd_ack_i     (sd.sd_ack),
        .lba_o        (seq_lba),
        .req_o        (seq_req),
        .sec_o        (seq_sec),
        .first_done_o (seq_first),
        .done_o       (seq_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= DS_IDLE;
            cur_track_q  <= '1;
            cpu_wait_q   <= 1'b0;
            mount_pend_q <= 1'b0;
            abort_pend_q <= 1'b0;
            start_q      <= 1'b0;
            base_q       <= '0;
`ifdef DISK_WRITEBACK_EN
            dirty_q      <= 1'b0;
            flush_pend_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                DS_IDLE: begin
                    cpu_wait_q <= 1'b0;
                    if (mount_pend_q) begin
                        mount_pend_q <= 1'b0;
`ifdef DISK_WRITEBACK_EN
                        dirty_q      <= 1'b0;
`endif
                        // Without an image, forget the resident track so the next image reloads.
                        if (!has_img) begin
                            cur_track_q <= '1;
                        end
                    end
`ifdef DISK_WRITEBACK_EN
                    if (wb_go) begin
                        state_q    <= DS_WB;
                        cpu_wait_q <= 1'b1;
                        start_q    <= 1'b1;
                        base_q     <= track_lba(32'(cur_track_q), SECTORS);
                    end else
`endif
                    if (rd_go) begin
                        state_q     <= DS_RD;
                        cpu_wait_q  <= 1'b1;
                        start_q     <= 1'b1;
                        cur_track_q <= track;
                        base_q      <= track_lba(32'(track), SECTORS);
                    end
`ifdef DISK_WRITEBACK_EN
                    else if (!mount_pend_q && flush_pend_q && !dirty_q) begin
                        flush_pend_q <= 1'b0;
                    end
`endif
                end
`ifdef DISK_WRITEBACK_EN
                DS_WB: begin
                    // cpu_wait is left high so a following read keeps the CPU stalled.
                    if (seq_done) begin
                        state_q      <= DS_IDLE;
                        abort_pend_q <= 1'b0;
                        if (!abort_pend_q) begin
                            dirty_q      <= 1'b0;
                            flush_pend_q <= 1'b0;
                        end
                    end
                end
`endif
                DS_RD: begin
                    if (seq_first) begin
                        cpu_wait_q <= 1'b0;
                    end
                    if (seq_done) begin
                        state_q      <= DS_IDLE;
                        abort_pend_q <= 1'b0;
                    end
                end
                default: state_q <= DS_IDLE;
            endcase

`ifdef DISK_WRITEBACK_EN
            if (track_dirty && state_q != DS_WB) begin
                dirty_q <= 1'b1;
            end
            if (flush) begin
                flush_pend_q <= 1'b1;
            end
`endif
            // A mount landing on the final sector needs no abort; the reload follows anyway.
            if (img_mounted) begin
                mount_pend_q <= 1'b1;
                if (state_q != DS_IDLE && !seq_done) begin
                    abort_pend_q <= 1'b1;
                end
            end
        end
    end

    assign sd.sd_lba = seq_lba;
    assign sd.sd_rd  = seq_req & (state_q == DS_RD);
`ifdef DISK_WRITEBACK_EN
    assign sd.sd_wr  = seq_req & (state_q == DS_WB);
    assign dirty     = dirty_q;
`else
    assign sd.sd_wr  = 1'b0;
    assign dirty     = 1'b0;
`endif
    assign track_sec = seq_sec;
    assign cpu_wait  = cpu_wait_q;
    assign busy      = (state_q != DS_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_disk_track_sync.sv
// Bench for disk_track_sync: SD host model logs every sector as {wr, cpu_wait, track_sec, lba}.
// Builds with or without DISK_WRITEBACK_EN; expectations follow the build.
module tb_disk_track_sync;
    import apple2_disk_pkg::*;

    localparam logic [63:0] IMG = 64'd143360;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        track_dirty;
    logic        flush;
    logic        img_mounted;
    logic [63:0] img_size;
    logic [3:0]  track_sec;
    logic        cpu_wait;
    logic        busy;
    logic        dirty;
    disk_state_t state_dbg;

    disk_track_sync_if sd();

    disk_track_sync dut (
        .clk_sys     (clk),
        .reset       (reset),
        .track       (track),
        .track_dirty (track_dirty),
        .flush       (flush),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .sd          (sd),
        .track_sec   (track_sec),
        .cpu_wait    (cpu_wait),
        .busy        (busy),
        .dirty       (dirty),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    logic [37:0] act_q[$];
    logic [37:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int wr_cycles = 0;
    int sec_over = 0;
    int quiet_viol = 0;
    logic watch_quiet = 1'b0;

    typedef struct {
        logic [5:0]  trk;
        logic        do_dirty;
        logic        do_flush;
        logic [31:0] wr_base;
        int          wr_n;
        logic [31:0] rd_base;
        int          rd_n;
        logic        exp_dirty;
    } vec_t;

    vec_t vecs[7];

    // SD host: ack rises 3 cycles after a request, stays 64 cycles, then 4+ cycles low.
    initial begin
        sd.sd_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sd.sd_rd || sd.sd_wr) begin
                repeat (3) @(posedge clk);
                #1;
                act_q.push_back({sd.sd_wr, cpu_wait, track_sec, sd.sd_lba});
                sd.sd_ack = 1'b1;
                repeat (64) @(posedge clk);
                #1 sd.sd_ack = 1'b0;
                repeat (4) @(posedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (sd.sd_wr) wr_cycles++;
        if (sd.sd_ack && track_sec > 4'd12) sec_over++;
        if (watch_quiet && (busy || cpu_wait || sd.sd_rd || sd.sd_wr)) quiet_viol++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic pulse_dirty();
        @(posedge clk); #1 track_dirty = 1'b1;
        @(posedge clk); #1 track_dirty = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_mount();
        @(posedge clk); #1 img_mounted = 1'b1;
        @(posedge clk); #1 img_mounted = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic push_burst(input logic wr, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({wr, (wr | (i == 0)), 4'(i), base + 32'(i)});
        end
    endtask

    task automatic wait_quiet(input string name);
        int stable = 0;
        int n = 0;
        repeat (10) @(posedge clk);
        while (stable < 12 && n < 6000) begin
            @(posedge clk); #1;
            n++;
            if (!busy && !sd.sd_ack && !sd.sd_rd && !sd.sd_wr) stable++;
            else stable = 0;
        end
        check({name, " settle"}, 64'(stable >= 12), 64'd1);
    endtask

    task automatic compare_log(input string name);
        check({name, " count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                check($sformatf("%s xfer[%0d]", name, i), 64'(act_q[i]), 64'(exp_q[i]));
            end
        end
    endtask

    task automatic run_row(input vec_t v, input string name);
        act_q.delete();
        exp_q.delete();
        if (v.do_dirty) pulse_dirty();
        track = v.trk;
        if (v.do_flush) pulse_flush();
        push_burst(1'b1, v.wr_base, v.wr_n);
        push_burst(1'b0, v.rd_base, v.rd_n);
        wait_quiet(name);
        compare_log(name);
        check({name, " dirty"}, 64'(dirty), 64'(v.exp_dirty));
        check({name, " cpu_wait"}, 64'(cpu_wait), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        track = 6'd0;
        track_dirty = 1'b0;
        flush = 1'b0;
        img_mounted = 1'b0;
        img_size = 64'd0;

        vecs[0] = '{6'd0, 1'b0, 1'b0, 32'd0, 0, 32'd0, 13, 1'b0};
        vecs[1] = '{6'd3, 1'b0, 1'b0, 32'd0, 0, 32'd39, 13, 1'b0};
`ifdef DISK_WRITEBACK_EN
        vecs[2] = '{6'd4, 1'b1, 1'b0, 32'd39, 13, 32'd52, 13, 1'b0};
        vecs[4] = '{6'd5, 1'b1, 1'b0, 32'd0, 0, 32'd0, 0, 1'b1};
        vecs[5] = '{6'd5, 1'b0, 1'b1, 32'd65, 13, 32'd0, 0, 1'b0};
`else
        vecs[2] = '{6'd4, 1'b1, 1'b0, 32'd0, 0, 32'd52, 13, 1'b0};
        vecs[4] = '{6'd5, 1'b1, 1'b0, 32'd0, 0, 32'd0, 0, 1'b0};
        vecs[5] = '{6'd5, 1'b0, 1'b1, 32'd0, 0, 32'd0, 0, 1'b0};
`endif
        vecs[3] = '{6'd5, 1'b0, 1'b0, 32'd0, 0, 32'd65, 13, 1'b0};
        vecs[6] = '{6'd5, 1'b0, 1'b1, 32'd0, 0, 32'd0, 0, 1'b0};

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reset sd_lba", 64'(sd.sd_lba), 64'd0);
        check("reset sd_rd", 64'(sd.sd_rd), 64'd0);
        check("reset sd_wr", 64'(sd.sd_wr), 64'd0);
        check("reset cpu_wait", 64'(cpu_wait), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset dirty", 64'(dirty), 64'd0);
        check("reset track_sec", 64'(track_sec), 64'd0);

        img_size = IMG;
        for (int r = 0; r < 7; r++) begin
            run_row(vecs[r], $sformatf("row%0d", r));
        end

        // Mount after the third sector of a burst: four sectors move, then the current track reloads.
        act_q.delete();
        exp_q.delete();
`ifdef DISK_WRITEBACK_EN
        pulse_dirty();
        pulse_flush();
        push_burst(1'b1, 32'd65, 4);
        push_burst(1'b0, 32'd65, 13);
`else
        track = 6'd6;
        push_burst(1'b0, 32'd78, 4);
        push_burst(1'b0, 32'd78, 13);
`endif
        n = 0;
        while (!(act_q.size() == 3 && !sd.sd_ack) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check("abort reach sector 3", 64'(n < 3000), 64'd1);
        img_mounted = 1'b1;
        @(posedge clk); #1 img_mounted = 1'b0;
        wait_quiet("abort");
        compare_log("abort");
        check("abort dirty", 64'(dirty), 64'd0);
        check("abort cpu_wait", 64'(cpu_wait), 64'd0);

        // No image: nothing moves and a mount clears dirty.
        img_size = 64'd0;
        pulse_dirty();
`ifdef DISK_WRITEBACK_EN
        check("noimg dirty set", 64'(dirty), 64'd1);
`else
        check("noimg dirty set", 64'(dirty), 64'd0);
`endif
        pulse_mount();
        check("noimg dirty cleared", 64'(dirty), 64'd0);
        act_q.delete();
        track = 6'd7;
        watch_quiet = 1'b1;
        repeat (300) @(posedge clk);
        watch_quiet = 1'b0;
        check("noimg quiet", 64'(quiet_viol), 64'd0);
        check("noimg xfers", 64'(act_q.size()), 64'd0);

        // Image returns: the track under the head loads.
        act_q.delete();
        exp_q.delete();
        push_burst(1'b0, 32'd91, 13);
        img_size = IMG;
        wait_quiet("reload");
        compare_log("reload");

        check("track_sec bound", 64'(sec_over), 64'd0);
`ifdef DISK_WRITEBACK_EN
        check("sd_wr used", 64'(wr_cycles > 0), 64'd1);
`else
        check("sd_wr never", 64'(wr_cycles), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
